draw_text_box: RTL and testbench
================================

Name: draw_text_box

Overview:
- Parametrised text-window overlay for the VGA pixel pipeline; successor to the fixed 16x16-character, 8x16-font, black-only overlay.
- Draws a COLS x ROWS grid of 8x16 glyphs, optionally magnified by 2^SCALE_LOG2.
- Position, colours, enable and transparency mode are runtime inputs, shadow-registered at vertical blank so the window never tears mid-frame.
- Sits between the background/rect stages and the VGA output. Drives an external char buffer and font ROM with a configurable read latency.

Parameters:
- COL_BITS, 4, log2 of text columns (COLS = 2^COL_BITS).
- ROW_BITS, 4, log2 of text rows (ROWS = 2^ROW_BITS).
- SCALE_LOG2, 0, glyph magnification exponent; legal values 0..2 (1x, 2x, 4x).
- ROM_LAT, 2, clocks from the char_yx/char_line register edge to char_pixels valid; legal values 1..3.
- XPOS_RST, 640, reset value of the window x origin.
- YPOS_RST, 100, reset value of the window y origin.
- FG_RST, 12'h000, reset foreground colour.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- vcount_in  in  11  vertical pixel count.
- vsync_in  in  1  vertical sync.
- vblnk_in  in  1  vertical blank.
- hcount_in  in  11  horizontal pixel count.
- hsync_in  in  1  horizontal sync.
- hblnk_in  in  1  horizontal blank.
- rgb_in  in  12  upstream colour.
- xpos  in  11  requested window x origin.
- ypos  in  11  requested window y origin.
- fg_color  in  12  glyph colour.
- bg_color  in  12  cell background colour.
- bg_en  in  1  1 = paint bg_color on 0-bits; 0 = transparent (pass rgb).
- enable  in  1  overlay on/off.
- char_yx  out  ROW_BITS+COL_BITS  {row,col} address to the char buffer.
- char_line  out  4  glyph line to the font ROM.
- char_pixels  in  8  glyph row; bit 7 is the leftmost pixel.
- vcount_out, vsync_out, vblnk_out, hcount_out, hsync_out, hblnk_out  out  11/1/1/11/1/1  timing delayed by L.
- rgb_out  out  12  composited colour.

Behaviour:
- Latency L = 1 + ROM_LAT clocks for all outputs relative to the inputs. Timing signals and rgb_in go through an L-deep register pipeline.
- Shadow registers:
  - Registered set: xpos_q, ypos_q, fg_q, bg_q, bg_en_q, enable_q.
  - Load condition: load from the inputs on the cycle where vblnk_in=1 and the registered previous vblnk was 0 (rising edge of vblnk_in). Hold otherwise.
  - Reset values: XPOS_RST, YPOS_RST, FG_RST, 12'h000, 0, 1.
- Geometry, using 12-bit subtraction:
  - hrel = hcount_in - xpos_q; vrel = vcount_in - ypos_q.
  - in_box = !hblnk && !vblnk && hcount_in >= xpos_q && vcount_in >= ypos_q && hrel < (8*COLS)<<SCALE_LOG2 && vrel < (16*ROWS)<<SCALE_LOG2.
  - All compares are unsigned in 12 bits, so a window extending past the screen clips and never wraps.
  - hs = hrel>>SCALE_LOG2; vs = vrel>>SCALE_LOG2.
- Stage 1 (edge 1):
  - char_yx <= {vs[ROW_BITS+3:4], hs[COL_BITS+2:3]}; char_line <= vs[3:0].
  - Outside the box, char_yx and char_line still update from the truncated values. They are don't-care for the consumer.
- Pixel column pix = hs[2:0] and in_box are carried through the pipeline alongside timing, so they align with char_pixels at edge L.
- Edge L rgb_out selection, in priority order:
  - enable_q=0 or !in_box_d → rgb_d.
  - char_pixels[7-pix_d]=1 → fg_q.
  - bg_en_q=1 → bg_q.
  - else → rgb_d.
- Colour and mode used at edge L are the shadow values. A shadow load landing while pixels are in flight affects only pixels sampled after the load. This is acceptable because loads occur only in vblank.
- Reset:
  - rgb_out, char_yx, char_line, all delayed timing outputs and all pipeline stages clear to 0 on the next edge.
  - Shadow registers take their reset values.
  - Reset mid-frame aborts the current drawing. Valid output resumes L clocks after rst deasserts, using the reset defaults until the next vblank edge.

Test Plan:
- Defaults, SCALE_LOG2=0, ROM_LAT=2, font model returns 8'hA5 for all addresses → at hcount 640..647, vcount 100: rgb_out = 000,rgb,000,rgb,rgb,000,rgb,000 at L=3 clocks. hcount 639 and 768 pass rgb_in.
- Address check: hcount=640+8*5+3, vcount=100+16*2+7 → char_yx=8'h25, char_line=7 one clock after the input.
- SCALE_LOG2=1 → each glyph pixel spans 2 columns and 2 lines. Box right edge passes at hcount=640+256; bottom passes at vcount=100+512.
- Shadow timing: change xpos to 10 mid-frame → current frame still draws at 640. After the vblnk_in rising edge, the next frame draws at 10.
- bg_en=1, bg_color=12'hF00, char_pixels=0 → whole box 12'hF00. With bg_en=0 → rgb_in passes. With enable=0 → rgb_in passes everywhere.
- Assert rst for 1 cycle mid-box → the following cycle all outputs are 0. Output matches the delayed reference with default position 3 clocks after release. Blanking inside the box range passes rgb_in.

Source files
------------

// File: rtl/draw_text_box.sv
// draw_text_box: text-window overlay for the VGA pixel pipeline.
//
// Draws a COLS x ROWS grid of 8x16 glyphs, magnified by 2^SCALE_LOG2, on top of
// the upstream pixel stream. Position, colours, enable and transparency mode are
// shadow-registered on the rising edge of vblnk_in so a frame never tears.
// All outputs lag the inputs by L = 1 + ROM_LAT clocks.
//
// Ports:
//   clk, rst                 pixel clock, synchronous active-high reset
//   vcount_in .. rgb_in      upstream timing and colour
//   xpos, ypos               requested window origin (shadowed)
//   fg_color, bg_color       glyph and cell background colours (shadowed)
//   bg_en                    1 = paint bg_color on 0-bits, 0 = transparent
//   enable                   overlay on/off (shadowed)
//   char_yx, char_line       {row,col} char buffer address and glyph line to font ROM
//   char_pixels              glyph row from font ROM, bit 7 leftmost
//   vcount_out .. rgb_out    delayed timing and composited colour

module draw_text_box #(
    parameter int unsigned COL_BITS   = 4,
    parameter int unsigned ROW_BITS   = 4,
    parameter int unsigned SCALE_LOG2 = 0,
    parameter int unsigned ROM_LAT    = 2,
    parameter logic [10:0] XPOS_RST   = 11'd640,
    parameter logic [10:0] YPOS_RST   = 11'd100,
    parameter logic [11:0] FG_RST     = 12'h000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [10:0]                  vcount_in,
    input  logic                         vsync_in,
    input  logic                         vblnk_in,
    input  logic [10:0]                  hcount_in,
    input  logic                         hsync_in,
    input  logic                         hblnk_in,
    input  logic [11:0]                  rgb_in,
    input  logic [10:0]                  xpos,
    input  logic [10:0]                  ypos,
    input  logic [11:0]                  fg_color,
    input  logic [11:0]                  bg_color,
    input  logic                         bg_en,
    input  logic                         enable,
    output logic [ROW_BITS+COL_BITS-1:0] char_yx,
    output logic [3:0]                   char_line,
    input  logic [7:0]                   char_pixels,
    output logic [10:0]                  vcount_out,
    output logic                         vsync_out,
    output logic                         vblnk_out,
    output logic [10:0]                  hcount_out,
    output logic                         hsync_out,
    output logic                         hblnk_out,
    output logic [11:0]                  rgb_out
);

    localparam int unsigned LAT = 1 + ROM_LAT;
    localparam logic [12:0] BOX_W = 13'((8 << COL_BITS) << SCALE_LOG2);
    localparam logic [12:0] BOX_H = 13'((16 << ROW_BITS) << SCALE_LOG2);

    // ------------------------------------------------------------------
    // Shadow registers, loaded on the rising edge of vblnk_in
    // ------------------------------------------------------------------
    logic [10:0] xpos_q, ypos_q;
    logic [11:0] fg_q, bg_q;
    logic        bg_en_q, enable_q;
    logic        vblnk_prev_q;
    logic        load;

    assign load = vblnk_in && !vblnk_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_prev_q <= 1'b0;
            xpos_q       <= XPOS_RST;
            ypos_q       <= YPOS_RST;
            fg_q         <= FG_RST;
            bg_q         <= 12'h000;
            bg_en_q      <= 1'b0;
            enable_q     <= 1'b1;
        end else begin
            vblnk_prev_q <= vblnk_in;
            if (load) begin
                xpos_q   <= xpos;
                ypos_q   <= ypos;
                fg_q     <= fg_color;
                bg_q     <= bg_color;
                bg_en_q  <= bg_en;
                enable_q <= enable;
            end
        end
    end

    // ------------------------------------------------------------------
    // Geometry: 12-bit unsigned so an oversize window clips, never wraps
    // ------------------------------------------------------------------
    logic [11:0]           hrel, vrel;
    logic [COL_BITS+2:0]   hs;
    logic [ROW_BITS+3:0]   vs;
    logic                  in_box;

    assign hrel = {1'b0, hcount_in} - {1'b0, xpos_q};
    assign vrel = {1'b0, vcount_in} - {1'b0, ypos_q};
    assign hs   = (COL_BITS + 3)'(hrel >> SCALE_LOG2);
    assign vs   = (ROW_BITS + 4)'(vrel >> SCALE_LOG2);

    assign in_box = !hblnk_in && !vblnk_in &&
                    (hcount_in >= xpos_q) && (vcount_in >= ypos_q) &&
                    ({1'b0, hrel} < BOX_W) && ({1'b0, vrel} < BOX_H);

    // ------------------------------------------------------------------
    // Stage 1: font/char-buffer address
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            char_yx   <= '0;
            char_line <= 4'd0;
        end else begin
            char_yx   <= {vs[ROW_BITS+3:4], hs[COL_BITS+2:3]};
            char_line <= vs[3:0];
        end
    end

    // ------------------------------------------------------------------
    // Delay pipelines. Timing runs LAT deep; colour, in_box and pixel
    // column run LAT-1 deep so they meet char_pixels at edge LAT.
    // ------------------------------------------------------------------
    logic [10:0] vcount_pipe [LAT];
    logic [10:0] hcount_pipe [LAT];
    logic        vsync_pipe  [LAT];
    logic        vblnk_pipe  [LAT];
    logic        hsync_pipe  [LAT];
    logic        hblnk_pipe  [LAT];
    logic [11:0] rgb_pipe    [LAT-1];
    logic        in_box_pipe [LAT-1];
    logic [2:0]  pix_pipe    [LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                vcount_pipe[i] <= 11'd0;
                hcount_pipe[i] <= 11'd0;
                vsync_pipe[i]  <= 1'b0;
                vblnk_pipe[i]  <= 1'b0;
                hsync_pipe[i]  <= 1'b0;
                hblnk_pipe[i]  <= 1'b0;
            end
            for (int i = 0; i < LAT - 1; i++) begin
                rgb_pipe[i]    <= 12'h000;
                in_box_pipe[i] <= 1'b0;
                pix_pipe[i]    <= 3'd0;
            end
        end else begin
            vcount_pipe[0] <= vcount_in;
            hcount_pipe[0] <= hcount_in;
            vsync_pipe[0]  <= vsync_in;
            vblnk_pipe[0]  <= vblnk_in;
            hsync_pipe[0]  <= hsync_in;
            hblnk_pipe[0]  <= hblnk_in;
            rgb_pipe[0]    <= rgb_in;
            in_box_pipe[0] <= in_box;
            pix_pipe[0]    <= hs[2:0];
            for (int i = 1; i < LAT; i++) begin
                vcount_pipe[i] <= vcount_pipe[i-1];
                hcount_pipe[i] <= hcount_pipe[i-1];
                vsync_pipe[i]  <= vsync_pipe[i-1];
                vblnk_pipe[i]  <= vblnk_pipe[i-1];
                hsync_pipe[i]  <= hsync_pipe[i-1];
                hblnk_pipe[i]  <= hblnk_pipe[i-1];
            end
            for (int i = 1; i < LAT - 1; i++) begin
                rgb_pipe[i]    <= rgb_pipe[i-1];
                in_box_pipe[i] <= in_box_pipe[i-1];
                pix_pipe[i]    <= pix_pipe[i-1];
            end
        end
    end

    assign vcount_out = vcount_pipe[LAT-1];
    assign hcount_out = hcount_pipe[LAT-1];
    assign vsync_out  = vsync_pipe[LAT-1];
    assign vblnk_out  = vblnk_pipe[LAT-1];
    assign hsync_out  = hsync_pipe[LAT-1];
    assign hblnk_out  = hblnk_pipe[LAT-1];

    // ------------------------------------------------------------------
    // Edge LAT: composite using shadow colours
    // ------------------------------------------------------------------
    logic [11:0] rgb_d;
    logic        in_box_d;
    logic [2:0]  pix_d;
    logic        pixel_on;
    logic [11:0] rgb_nxt;

    assign rgb_d    = rgb_pipe[LAT-2];
    assign in_box_d = in_box_pipe[LAT-2];
    assign pix_d    = pix_pipe[LAT-2];
    assign pixel_on = char_pixels[3'd7 - pix_d];

    always_comb begin
        rgb_nxt = rgb_d;
        if (enable_q && in_box_d) begin
            if (pixel_on) begin
                rgb_nxt = fg_q;
            end else if (bg_en_q) begin
                rgb_nxt = bg_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_out <= 12'h000;
        end else begin
            rgb_out <= rgb_nxt;
        end
    end

endmodule

// File: tb/tb_draw_text_box.sv
module tb_draw_text_box;

    localparam int LAT = 3;
    localparam logic [11:0] RGB = 12'h3C7;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] vcount_in, hcount_in, xpos, ypos;
    logic        vsync_in, vblnk_in, hsync_in, hblnk_in, bg_en, enable;
    logic [11:0] rgb_in, fg_color, bg_color;
    logic [7:0]  char_pixels;

    logic [7:0]  char_yx, char_yx2;
    logic [3:0]  char_line, char_line2;
    logic [10:0] vcount_out, hcount_out, vcount_out2, hcount_out2;
    logic        vsync_out, vblnk_out, hsync_out, hblnk_out;
    logic        vsync_out2, vblnk_out2, hsync_out2, hblnk_out2;
    logic [11:0] rgb_out, rgb_out2;

    int checks = 0;
    int failures = 0;

    logic [10:0] seq_h [16];
    logic [10:0] seq_v [16];
    logic        seq_hb [16];
    logic [11:0] exp_rgb [16];
    logic [11:0] got [16];
    logic [11:0] got2 [16];
    logic [10:0] goth [16];
    int          n_seq;

    always #5 clk = ~clk;

    draw_text_box #(.SCALE_LOG2(0), .ROM_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
        .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
        .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
        .fg_color(fg_color), .bg_color(bg_color), .bg_en(bg_en), .enable(enable),
        .char_yx(char_yx), .char_line(char_line), .char_pixels(char_pixels),
        .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
        .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
        .rgb_out(rgb_out)
    );

    draw_text_box #(.SCALE_LOG2(1), .ROM_LAT(2)) dut2 (
        .clk(clk), .rst(rst),
        .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
        .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
        .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
        .fg_color(fg_color), .bg_color(bg_color), .bg_en(bg_en), .enable(enable),
        .char_yx(char_yx2), .char_line(char_line2), .char_pixels(char_pixels),
        .vcount_out(vcount_out2), .vsync_out(vsync_out2), .vblnk_out(vblnk_out2),
        .hcount_out(hcount_out2), .hsync_out(hsync_out2), .hblnk_out(hblnk_out2),
        .rgb_out(rgb_out2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [10:0] h, input logic [10:0] v, input logic hb);
        hcount_in = h;
        vcount_in = v;
        hblnk_in  = hb;
        vblnk_in  = 1'b0;
        rgb_in    = RGB;
    endtask

    task automatic add(input logic [10:0] h, input logic [10:0] v, input logic hb,
                       input logic [11:0] e);
        seq_h[n_seq]   = h;
        seq_v[n_seq]   = v;
        seq_hb[n_seq]  = hb;
        exp_rgb[n_seq] = e;
        n_seq++;
    endtask

    // Drives the queued pixels back to back and captures each one's output LAT clocks later.
    task automatic play();
        for (int i = 0; i < n_seq + LAT - 1; i++) begin
            if (i < n_seq) drive(seq_h[i], seq_v[i], seq_hb[i]);
            else           drive(11'd0, 11'd0, 1'b1);
            tick();
            if (i >= LAT - 1) begin
                got[i-LAT+1]  = rgb_out;
                got2[i-LAT+1] = rgb_out2;
                goth[i-LAT+1] = hcount_out;
            end
        end
    endtask

    task automatic vblank_pulse();
        hblnk_in = 1'b1;
        vblnk_in = 1'b1;
        tick();
        tick();
        vblnk_in = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(11'd640, 11'd100, 1'b0);
        tick();
        tick();
        checks++;
        if (rgb_out !== 12'h000 || char_yx !== 8'h00 || hcount_out !== 11'd0) begin
            failures++;
            $display("FAIL reset_state rgb=%h yx=%h hc=%0d, required 000/00/0",
                     rgb_out, char_yx, hcount_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_defaults();
        char_pixels = 8'hA5;
        n_seq = 0;
        add(11'd639, 11'd100, 1'b0, RGB);
        add(11'd640, 11'd100, 1'b0, 12'h000);
        add(11'd641, 11'd100, 1'b0, RGB);
        add(11'd642, 11'd100, 1'b0, 12'h000);
        add(11'd643, 11'd100, 1'b0, RGB);
        add(11'd644, 11'd100, 1'b0, RGB);
        add(11'd645, 11'd100, 1'b0, 12'h000);
        add(11'd646, 11'd100, 1'b0, RGB);
        add(11'd647, 11'd100, 1'b0, 12'h000);
        add(11'd768, 11'd100, 1'b0, RGB);
        add(11'd767, 11'd100, 1'b0, 12'h000);
        add(11'd640, 11'd355, 1'b0, 12'h000);
        add(11'd640, 11'd356, 1'b0, RGB);
        play();
        for (int i = 0; i < n_seq; i++) begin
            checks++;
            if (got[i] !== exp_rgb[i]) begin
                failures++;
                $display("FAIL defaults[%0d] h=%0d v=%0d rgb_out=%h required %h",
                         i, seq_h[i], seq_v[i], got[i], exp_rgb[i]);
            end
            checks++;
            if (goth[i] !== seq_h[i]) begin
                failures++;
                $display("FAIL hcount_delay[%0d] hcount_out=%0d required %0d",
                         i, goth[i], seq_h[i]);
            end
        end
    endtask

    task automatic test_address();
        drive(11'd683, 11'd139, 1'b0);
        tick();
        checks++;
        if (char_yx !== 8'h25 || char_line !== 4'd7) begin
            failures++;
            $display("FAIL addr_25 yx=%h line=%0d required 25/7", char_yx, char_line);
        end
        checks++;
        if (char_yx2 !== 8'h12 || char_line2 !== 4'd3) begin
            failures++;
            $display("FAIL addr_x2 yx=%h line=%0d required 12/3", char_yx2, char_line2);
        end
        drive(11'd767, 11'd355, 1'b0);
        tick();
        checks++;
        if (char_yx !== 8'hFF || char_line !== 4'd15) begin
            failures++;
            $display("FAIL addr_ff yx=%h line=%0d required ff/15", char_yx, char_line);
        end
    endtask

    task automatic test_scale();
        char_pixels = 8'hA5;
        n_seq = 0;
        add(11'd640, 11'd100, 1'b0, 12'h000);
        add(11'd641, 11'd100, 1'b0, 12'h000);
        add(11'd642, 11'd100, 1'b0, RGB);
        add(11'd643, 11'd100, 1'b0, RGB);
        add(11'd895, 11'd100, 1'b0, 12'h000);
        add(11'd896, 11'd100, 1'b0, RGB);
        add(11'd640, 11'd611, 1'b0, 12'h000);
        add(11'd640, 11'd612, 1'b0, RGB);
        play();
        for (int i = 0; i < n_seq; i++) begin
            checks++;
            if (got2[i] !== exp_rgb[i]) begin
                failures++;
                $display("FAIL scale2[%0d] h=%0d v=%0d rgb_out=%h required %h",
                         i, seq_h[i], seq_v[i], got2[i], exp_rgb[i]);
            end
        end
    endtask

    task automatic test_shadow();
        char_pixels = 8'hA5;
        xpos = 11'd10;
        fg_color = 12'h0F0;
        n_seq = 0;
        add(11'd640, 11'd100, 1'b0, 12'h000);
        add(11'd10,  11'd100, 1'b0, RGB);
        play();
        for (int i = 0; i < n_seq; i++) begin
            checks++;
            if (got[i] !== exp_rgb[i]) begin
                failures++;
                $display("FAIL shadow_hold[%0d] rgb_out=%h required %h", i, got[i], exp_rgb[i]);
            end
        end
        vblank_pulse();
        n_seq = 0;
        add(11'd10,  11'd100, 1'b0, 12'h0F0);
        add(11'd11,  11'd100, 1'b0, RGB);
        add(11'd640, 11'd100, 1'b0, RGB);
        play();
        for (int i = 0; i < n_seq; i++) begin
            checks++;
            if (got[i] !== exp_rgb[i]) begin
                failures++;
                $display("FAIL shadow_load[%0d] rgb_out=%h required %h", i, got[i], exp_rgb[i]);
            end
        end
    endtask

    task automatic test_bg();
        xpos = 11'd640;
        ypos = 11'd100;
        fg_color = 12'h0F0;
        bg_color = 12'hF00;
        bg_en = 1'b1;
        enable = 1'b1;
        char_pixels = 8'h00;
        vblank_pulse();
        n_seq = 0;
        add(11'd640, 11'd100, 1'b0, 12'hF00);
        add(11'd700, 11'd200, 1'b0, 12'hF00);
        add(11'd767, 11'd355, 1'b0, 12'hF00);
        add(11'd639, 11'd100, 1'b0, RGB);
        add(11'd640, 11'd356, 1'b0, RGB);
        play();
        for (int i = 0; i < n_seq; i++) begin
            checks++;
            if (got[i] !== exp_rgb[i]) begin
                failures++;
                $display("FAIL bg_fill[%0d] rgb_out=%h required %h", i, got[i], exp_rgb[i]);
            end
        end
        bg_en = 1'b0;
        vblank_pulse();
        n_seq = 0;
        add(11'd640, 11'd100, 1'b0, RGB);
        play();
        checks++;
        if (got[0] !== RGB) begin
            failures++;
            $display("FAIL bg_transparent rgb_out=%h required %h", got[0], RGB);
        end
        char_pixels = 8'hA5;
        enable = 1'b0;
        vblank_pulse();
        n_seq = 0;
        add(11'd640, 11'd100, 1'b0, RGB);
        add(11'd642, 11'd100, 1'b0, RGB);
        play();
        for (int i = 0; i < n_seq; i++) begin
            checks++;
            if (got[i] !== RGB) begin
                failures++;
                $display("FAIL disabled[%0d] rgb_out=%h required %h", i, got[i], RGB);
            end
        end
    endtask

    task automatic test_reset_mid();
        // Inputs differ from the reset defaults so a stray load would show.
        xpos = 11'd10;
        fg_color = 12'h0F0;
        enable = 1'b0;
        char_pixels = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            drive(11'd683, 11'd139, 1'b0);
            tick();
        end
        rst = 1'b1;
        tick();
        checks++;
        if (rgb_out !== 12'h000 || hcount_out !== 11'd0 || vcount_out !== 11'd0 ||
            char_yx !== 8'h00 || char_line !== 4'd0 || hblnk_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid rgb=%h hc=%0d vc=%0d yx=%h line=%0d hb=%b required all 0",
                     rgb_out, hcount_out, vcount_out, char_yx, char_line, hblnk_out);
        end
        rst = 1'b0;
        n_seq = 0;
        add(11'd640, 11'd100, 1'b0, 12'h000);
        add(11'd641, 11'd100, 1'b0, RGB);
        add(11'd642, 11'd100, 1'b0, 12'h000);
        add(11'd10,  11'd100, 1'b0, RGB);
        add(11'd640, 11'd100, 1'b1, RGB);
        play();
        for (int i = 0; i < n_seq; i++) begin
            checks++;
            if (got[i] !== exp_rgb[i]) begin
                failures++;
                $display("FAIL after_reset[%0d] rgb_out=%h required %h", i, got[i], exp_rgb[i]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        vsync_in = 1'b0;
        hsync_in = 1'b0;
        vblnk_in = 1'b0;
        hblnk_in = 1'b0;
        hcount_in = 11'd0;
        vcount_in = 11'd0;
        rgb_in = RGB;
        xpos = 11'd640;
        ypos = 11'd100;
        fg_color = 12'h000;
        bg_color = 12'h000;
        bg_en = 1'b0;
        enable = 1'b1;
        char_pixels = 8'hA5;
        n_seq = 0;

        test_reset();
        test_defaults();
        test_address();
        test_scale();
        test_shadow();
        test_bg();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
